// File: rtl/drum_pkg.sv
// drum_pkg: shared types and sizing helpers for the DRUM multiply/divide datapaths
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bundle of the divider
interface seq_divider_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, dbz, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, dbz, quotient, remainder
    );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a bit, trial subtract, restore on borrow)
module div_step #(
    parameter int M = 4
) (
    input  logic [M:0]   rem_i,
    input  logic         bit_i,
    input  logic [M-1:0] dvs_i,
    output logic [M:0]   rem_o,
    output logic         q_o
);
    logic [M+1:0] sh;
    logic [M+1:0] diff;

    // partial remainder stays below the divisor, so the extra top bit of diff is a clean borrow
    always_comb begin
        sh    = {rem_i, bit_i};
        diff  = sh - {2'b00, dvs_i};
        q_o   = ~diff[M+1];
        rem_o = q_o ? diff[M:0] : sh[M:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock
module seq_divider
    import drum_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_divider_if.slave    bus
);
    localparam int CW = cnt_w(N);

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0] dvs_q, dvs_d;
    logic [N-1:0] sh_q, sh_d;
    logic [M:0]   rem_q, rem_d;
    logic [N-1:0] quo_q, quo_d;
    logic [M-1:0] remo_q, remo_d;
    logic         dbz_q, dbz_d;
    logic [M:0]   rem_n;
    logic         qb;

    div_step #(.M(M)) u_step (
        .rem_i (rem_q),
        .bit_i (sh_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_n),
        .q_o   (qb)
    );

    // sh_q shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        if (state_q != RUN && bus.start) begin
            dvs_d = bus.divisor;
            sh_d  = bus.dividend;
            rem_d = '0;
            cnt_d = CW'(N - 1);
            dbz_d = 1'b0;
            if (bus.divisor == '0) begin
                state_d = DONE;
                quo_d   = '1;
                remo_d  = bus.dividend[M-1:0];
                dbz_d   = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            sh_d  = {sh_q[N-2:0], qb};
            rem_d = rem_n;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = DONE;
                quo_d   = {sh_q[N-2:0], qb};
                remo_d  = rem_n[M-1:0];
            end
        end else begin
            state_d = IDLE;
        end
    end

    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.dbz       = dbz_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = remo_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider at N=8, M=4
module tb_seq_divider;
    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    seq_divider_if #(.N(N), .M(M)) bus ();

    seq_divider #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go(input int dd, input int ds);
        @(negedge clk);
        bus.dividend = dd[N-1:0];
        bus.divisor  = ds[M-1:0];
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // called just after the accepting edge; counts sampled cycles up to and including done
    task automatic wait_done(input string tag, input int lat_exp, input int busy_exp);
        int  lat = 0;
        int  bc = 0;
        bit  seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1;
            else bc += int'(bus.busy);
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, lat, lat_exp);
        chk({tag, " busy cycles"}, bc, busy_exp);
        chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_res(input string tag, input int q, input int r, input int z);
        chk({tag, " quotient"}, 32'(bus.quotient), q);
        chk({tag, " remainder"}, 32'(bus.remainder), r);
        chk({tag, " dbz"}, 32'(bus.dbz), z);
    endtask

    task automatic op(input string tag, input int dd, input int ds);
        go(dd, ds);
        if (ds == 0) begin
            wait_done(tag, 1, 0);
            check_res(tag, 255, dd % 16, 1);
        end else begin
            wait_done(tag, N + 1, N);
            check_res(tag, dd / ds, dd % ds, 0);
        end
    endtask

    initial begin
        int dd, ds, dcnt;
        bit seen;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        check_res("reset", 0, 0, 0);

        op("200/7", 200, 7);
        @(negedge clk);
        chk("done one cycle", 32'(bus.done), 0);
        check_res("held in idle", 28, 4, 0);

        op("255/15", 255, 15);
        op("6/2", 6, 2);
        op("5/9", 5, 9);
        op("100/0", 100, 0);
        op("100/3", 100, 3);

        go(200, 7);
        seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.dividend = 8'd50;
                bus.divisor  = 4'd5;
                bus.start    = 1'b1;
            end
            if (bus.done) begin
                seen = 1;
                chk("ignore start latency", i, N + 1);
            end
        end
        chk("ignore start done seen", 32'(seen), 1);
        check_res("ignore start", 28, 4, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("back-to-back", N + 1, N);
        check_res("back-to-back", 10, 0, 0);

        go(200, 7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort done", 32'(bus.done), 0);
        check_res("abort", 0, 0, 0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            dcnt += int'(bus.done);
        end
        chk("abort no done pulse", dcnt, 0);
        op("9/2", 9, 2);

        for (int i = 0; i < 300; i++) begin
            case (i)
                0: begin dd = 0;   ds = 1;  end
                1: begin dd = 255; ds = 1;  end
                2: begin dd = 255; ds = 0;  end
                3: begin dd = 0;   ds = 0;  end
                4: begin dd = 0;   ds = 15; end
                default: begin dd = $urandom_range(0, 255); ds = $urandom_range(0, 15); end
            endcase
            op($sformatf("rand %0d/%0d", dd, ds), dd, ds);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
